// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the elastic pipeline stage register.
//   - state_t     : occupancy state of the 2-entry skid stage
//   - control bit positions inside the control word
//   - default widths for the control word and status flags
//   - occ_of()    : maps a state onto its held-entry count
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    // Control word layout
    localparam int REG_WRITE   = 0;
    localparam int MEM_WRITE   = 1;
    localparam int MEM_TO_REG  = 2;
    localparam int ALU_SRC     = 3;
    localparam int ALU_CTRL_LO = 4;
    localparam int ALU_CTRL_HI = 5;

    localparam int DEF_CTRL_W   = 6;
    localparam int DEF_STATUS_W = 4;

    function automatic logic [1:0] occ_of(input state_t s);
        logic [1:0] n;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register {ctrl, data, status} with load enable.
//   clk, reset_n           : clock, asynchronous active-low reset (clears to 0)
//   load                   : capture d_* on the rising edge
//   d_ctrl/d_data/d_status : next payload
//   q_ctrl/q_data/q_status : held payload
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = 32,
    parameter int STATUS_W = DEF_STATUS_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [CTRL_W-1:0]   d_ctrl,
    input  logic [DATA_W-1:0]   d_data,
    input  logic [STATUS_W-1:0] d_status,
    output logic [CTRL_W-1:0]   q_ctrl,
    output logic [DATA_W-1:0]   q_data,
    output logic [STATUS_W-1:0] q_status
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_ctrl   <= '0;
            q_data   <= '0;
            q_status <= '0;
        end else if (load) begin
            q_ctrl   <= d_ctrl;
            q_data   <= d_data;
            q_status <= d_status;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with a 2-entry skid buffer.
//   clk, reset_n      : clock, asynchronous active-low reset
//   flush             : squash all held entries (beats every handshake)
//   stat_clear        : zero stall_cycles (beats a simultaneous increment)
//   in_valid/in_ready : upstream handshake; in_ready is registered
//   in_ctrl/data/status  : incoming entry
//   out_valid/out_ready  : downstream handshake
//   out_ctrl/data/status : head entry; out_ctrl is zero while out_valid=0
//   occupancy         : held entries (0..2)
//   stall_cycles      : saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = 32,
    parameter int STATUS_W = DEF_STATUS_W,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                stat_clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [STATUS_W-1:0] in_status,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [DATA_W-1:0]   out_data,
    output logic [STATUS_W-1:0] out_status,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_INC = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_nx;
    logic   accept, take;
    logic   main_load, skid_load, main_from_skid;

    logic [CTRL_W-1:0]   main_ctrl, skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0]   main_data, skid_data, main_d_data;
    logic [STATUS_W-1:0] main_status, skid_status, main_d_status;

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;

    always_comb begin
        state_nx       = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state_nx  = ONE;
                    main_load = 1'b1;
                end
                ONE: begin
                    if (accept && take) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        state_nx  = TWO;
                        skid_load = 1'b1;
                    end else if (take) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: if (take) begin
                    state_nx       = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            // Registered from next state so out_ready never reaches in_ready combinationally.
            in_ready <= (state_nx != TWO);
        end
    end

    // Main either takes the fresh input or is refilled from skid on a drain.
    assign main_d_ctrl   = main_from_skid ? skid_ctrl   : in_ctrl;
    assign main_d_data   = main_from_skid ? skid_data   : in_data;
    assign main_d_status = main_from_skid ? skid_status : in_status;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .STATUS_W(STATUS_W)) u_main (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (main_load),
        .d_ctrl   (main_d_ctrl),
        .d_data   (main_d_data),
        .d_status (main_d_status),
        .q_ctrl   (main_ctrl),
        .q_data   (main_data),
        .q_status (main_status)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .STATUS_W(STATUS_W)) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (skid_load),
        .d_ctrl   (in_ctrl),
        .d_data   (in_data),
        .d_status (in_status),
        .q_ctrl   (skid_ctrl),
        .q_data   (skid_data),
        .q_status (skid_status)
    );

    // A bubble must never carry write enables downstream.
    assign out_ctrl   = out_valid ? main_ctrl : '0;
    assign out_data   = main_data;
    assign out_status = main_status;
    assign occupancy  = occ_of(state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (stat_clear) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_INC;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int CW = 6, DW = 64, SW = 1, NW = 3;
    localparam int CMAX = (1 << NW) - 1;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          flush = 1'b0, stat_clear = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic [SW-1:0] in_status = '0;
    logic          out_valid, out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_status;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cycles;

    int checks = 0, errors = 0;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } ent_t;

    ent_t q[$];        // reference: entries held by the stage, head first
    int   exp_cnt = 0; // reference stall count
    bit   m_take, m_acc;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STATUS_W(SW), .CNT_W(NW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .stat_clear(stat_clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_status(in_status), .out_valid(out_valid),
        .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .out_status(out_status), .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            exp_cnt = 0;
        end else begin
            if (stat_clear) exp_cnt = 0;
            else if (q.size() > 0 && !out_ready && exp_cnt < CMAX) exp_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                m_take = (q.size() > 0) && out_ready;
                m_acc  = in_valid && (q.size() < 2);
                if (m_take) void'(q.pop_front());
                if (m_acc) q.push_back('{in_ctrl, in_data, in_status});
            end
        end
    end

    // Monitor: compare DUT against the reference mid-cycle.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", in_ready, q.size() < 2);
            chk("occupancy", occupancy, q.size());
            chk("out_valid", out_valid, q.size() > 0);
            chk("stall_cycles", stall_cycles, exp_cnt);
            if (q.size() > 0) begin
                chk("out_ctrl", out_ctrl, q[0].c);
                chk("out_data", out_data, q[0].d);
                chk("out_status", out_status, q[0].s);
            end else begin
                chk("bubble_ctrl", out_ctrl, 0);
            end
        end
    end

    task automatic step(input bit v, input logic [CW-1:0] c, input bit ordy,
                        input bit fl, input bit sc);
        in_valid   = v;
        in_ctrl    = c;
        in_data    = {$urandom, $urandom};
        in_status  = SW'($urandom);
        out_ready  = ordy;
        flush      = fl;
        stat_clear = sc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_status", out_status, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_stall", stall_cycles, 0);

        // Stream at full rate
        step(1, 6'h21, 1, 0, 0);
        chk("stream_first", out_ctrl, 6'h21);
        step(1, 6'h12, 1, 0, 0);
        chk("stream_second", out_ctrl, 6'h12);
        step(1, 6'h3F, 1, 0, 0);
        chk("stream_third", out_ctrl, 6'h3F);
        step(0, 0, 1, 0, 0);
        chk("stream_stall", stall_cycles, 0);

        // Back-pressure
        step(1, 6'h01, 0, 0, 0);
        step(1, 6'h02, 0, 0, 0);
        chk("bp_occ", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        step(0, 0, 1, 0, 0);
        chk("bp_head_b", out_ctrl, 6'h02);
        step(0, 0, 1, 0, 0);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_drained", occupancy, 0);

        // Flush at occupancy 2 with an incoming entry
        step(1, 6'h0A, 0, 0, 0);
        step(1, 6'h0B, 0, 0, 0);
        step(1, 6'h0C, 0, 1, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_out_ctrl", out_ctrl, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_in_ready", in_ready, 1);

        // Stall counter saturation
        step(0, 0, 0, 0, 1);
        step(1, 6'h07, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        chk("sat_stop", stall_cycles, CMAX);
        step(0, 0, 0, 0, 1);
        chk("sat_clear", stall_cycles, 0);
        step(0, 0, 1, 0, 0);

        // Async reset mid-stall at occupancy 2
        step(1, 6'h2A, 0, 0, 0);
        step(1, 6'h2B, 0, 0, 0);
        chk("ar_occ2", occupancy, 2);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_ctrl", out_ctrl, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_stall", stall_cycles, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step(1, 6'h15, 1, 0, 0);
        chk("ar_new_valid", out_valid, 1);
        chk("ar_new_ctrl", out_ctrl, 6'h15);
        step(0, 0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
        repeat (3) step(0, 0, 1, 0, 0);
        chk("final_empty", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register that succeeds the fixed ID/EX control latch. It carries a control word, a data payload and status flags between two pipeline stages under a valid/ready handshake. A 2-entry skid buffer gives full throughput with a registered `in_ready`. It adds flush, bubble squashing and a saturating back-pressure counter, and is instantiated at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `CTRL_W`, default 6: control word width (reg_write, mem_write, mem_to_reg, alu_src, alu_control[1:0]).
- `DATA_W`, default 32: payload width (operands, immediate, destination index packed by the instantiating stage).
- `STATUS_W`, default 4: status flag width (N, Z, C, V).
- `CNT_W`, default 8: stall counter width.
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `flush`, input, 1: synchronous squash of all held entries.
- `stat_clear`, input, 1: synchronous clear of `stall_cycles`.
- `in_valid`, input, 1: upstream entry present.
- `in_ready`, output, 1: stage can accept an entry; registered.
- `in_ctrl`, input, CTRL_W: control word.
- `in_data`, input, DATA_W: payload.
- `in_status`, input, STATUS_W: status flags.
- `out_valid`, output, 1: head entry present.
- `out_ready`, input, 1: downstream accepts the head entry.
- `out_ctrl`, output, CTRL_W: head control word; all-zero whenever `out_valid`=0.
- `out_data`, output, DATA_W: head payload.
- `out_status`, output, STATUS_W: head flags.
- `occupancy`, output, 2: held entries, 0 to 2.
- `stall_cycles`, output, CNT_W: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Accept when `in_valid && in_ready`. Take when `out_valid && out_ready`.
- Storage: main slot drives the outputs. Skid slot holds one extra entry.
- States:
  - EMPTY (occ 0):
    - accept -> ONE, main loads the input.
  - ONE (occ 1):
    - accept and take -> ONE, main reloads.
    - accept only -> TWO, skid loads.
    - take only -> EMPTY.
    - neither -> ONE.
  - TWO (occ 2):
    - `in_ready`=0, so no accept is possible.
    - take -> ONE, skid moves to main.
    - no take -> TWO, both slots hold.
- `in_ready` is 1 exactly when the next state is not TWO. It is computed from next state and registered.
- Bubble squash: `out_ctrl` is forced to zero when `out_valid`=0, so a bubble is always a NOP (no register or memory write). `out_data` and `out_status` hold their last values when invalid.
- Flush:
  - Next state EMPTY; both slots are invalidated.
  - `in_ready` is 1 the following cycle.
  - Any accept or take in the flush cycle is discarded. The downstream must ignore a take that coincides with flush.
  - Flush has priority over all handshakes.
- `stall_cycles`:
  - Increments each stalled cycle and saturates at 2^CNT_W−1 (no wrap).
  - `stat_clear` zeroes it; clear wins over a simultaneous increment.
  - Flush does not affect it.
- Entries leave in strict arrival order. No entry is duplicated or lost except by flush.

## Timing
- Reset (async assert, sync release on `clk`):
  - state EMPTY, `out_valid`=0, `in_ready`=1.
  - `out_ctrl`, `out_data`, `out_status` all 0.
  - `occupancy`=0, `stall_cycles`=0.
- Latency: an entry accepted at edge k appears at the outputs after edge k (one cycle), provided the stage was not stalled.
- Throughput: 1 entry/cycle with `out_ready` held high.
- `in_ready` deasserts the cycle after the skid slot fills. No combinational path exists from `out_ready` to `in_ready`.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Structure
- Shared package `pipe_pkg`:
  - state encoding: EMPTY=2'b00, ONE=2'b01, TWO=2'b10.
  - control-bit positions: REG_WRITE=0, MEM_WRITE=1, MEM_TO_REG=2, ALU_SRC=3, ALU_CTRL=5:4.
  - default widths: CTRL_W=6, STATUS_W=4.
- One sub-module, `pipe_slot`: a single payload register {ctrl, data, status} with load enable and asynchronous active-low reset. It is instantiated twice (main, skid).

## Test plan
- Reset then stream: `out_ready`=1; inputs ctrl=6'h21, 6'h12, 6'h3F on consecutive cycles. Outputs show the same values one cycle later, back to back. `stall_cycles`=0.
- Back-pressure: `out_ready`=0 while sending A=6'h01, B=6'h02.
  - `occupancy` reaches 2.
  - `in_ready`=0 from the next cycle.
  - Raise `out_ready`: A then B emerge, and `in_ready` returns to 1.
- Flush at occupancy 2 with a simultaneous `in_valid`: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, and the incoming entry is dropped.
- Saturation: CNT_W=3, stall 10 cycles. `stall_cycles` stops at 7. `stat_clear` then gives 0.
- Async reset asserted mid-stall at occupancy 2: outputs zero with no clock edge. After release, a new entry 6'h15 passes with 1-cycle latency.
- Parameter sweep (DATA_W=64, STATUS_W=1): random valid/ready for 10k cycles. The scoreboard sees in-order, lossless delivery and `out_ctrl`=0 on every invalid cycle.
